// File: rtl/col_conv_pkg.sv
// Shared state type, sizing helpers and the round/saturate function for the column convolution array.
package col_conv_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  function automatic int acc_w(input int data_w, input int k);
    return 2 * data_w + $clog2(k);
  endfunction

  function automatic int out_w_calc(input int in_len, input int k, input int stride);
    return (in_len - k) / stride + 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round half-up at the binary point, then clamp into the signed result range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int frac_w, input int data_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (frac_w > 0) ? ((acc + (64'sd1 <<< (frac_w - 1))) >>> frac_w) : acc;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/col_mac_lane.sv
// One multiply-accumulate lane; sequencing and writeback formatting live in the parent.
module col_mac_lane
  import col_conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [DATA_W-1:0] tap,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = (2*DATA_W)'(sample) * (2*DATA_W)'(tap);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/col_conv_array.sv
// Time-multiplexed column convolution: LANES shared MAC lanes sweep COLS columns for CH kernels,
// looping channel, column group, output position and tap, with one writeback cycle per position.
module col_conv_array
  import col_conv_pkg::*;
#(
  parameter int  DATA_W = 16,
  parameter int  FRAC_W = 8,
  parameter int  IN_LEN = 28,
  parameter int  K      = 8,
  parameter int  STRIDE = 2,
  parameter int  COLS   = 11,
  parameter int  CH     = 2,
  parameter int  LANES  = 4,
  localparam int OUT_W  = out_w_calc(IN_LEN, K, STRIDE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic signed [DATA_W-1:0] in_cols [COLS][IN_LEN],
  input  logic signed [DATA_W-1:0] kernels [CH][K],
  output logic                     busy,
  output logic                     done,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_values [CH][COLS][OUT_W]
);

  localparam int G      = (COLS + LANES - 1) / LANES;
  localparam int ACC_W  = acc_w(DATA_W, K);
  localparam int CH_IW  = idx_w(CH);
  localparam int G_IW   = idx_w(G);
  localparam int POS_IW = idx_w(OUT_W);
  localparam int TAP_IW = idx_w(K + 1);
  localparam int KT_IW  = idx_w(K);
  localparam int COL_IW = idx_w(COLS);
  localparam int SMP_IW = idx_w(IN_LEN);

  if (STRIDE < 1 || K > IN_LEN || (IN_LEN - K) % STRIDE != 0 || LANES > COLS ||
      FRAC_W >= DATA_W || ACC_W > 64) begin : g_param_check
    $error("col_conv_array: illegal parameter combination");
  end

  state_e state_q, state_d;

  logic [CH_IW-1:0]  ch_q;
  logic [G_IW-1:0]   grp_q;
  logic [POS_IW-1:0] pos_q;
  logic [TAP_IW-1:0] tap_q;

  logic signed [DATA_W-1:0] col_reg [COLS][IN_LEN];
  logic signed [DATA_W-1:0] ker_reg [CH][K];
  logic                     relu_q;

  logic accept;
  logic wb;
  logic last_wb;
  logic lane_clr;
  logic lane_en;

  logic signed [DATA_W-1:0] kern_tap;
  logic signed [DATA_W-1:0] lane_sample [LANES];
  logic signed [ACC_W-1:0]  lane_acc    [LANES];
  logic signed [DATA_W-1:0] lane_res    [LANES];
  logic [COL_IW-1:0]        lane_col    [LANES];
  logic                     lane_ok     [LANES];

  // A start on the done-pulse cycle is still part of the finishing run and is dropped.
  assign accept   = (state_q == IDLE) && start && !done;
  assign wb       = (state_q == RUN) && (tap_q == TAP_IW'(K));
  assign last_wb  = wb && (pos_q == POS_IW'(OUT_W - 1)) && (grp_q == G_IW'(G - 1)) &&
                    (ch_q == CH_IW'(CH - 1));
  assign lane_clr = (state_q == LOAD) || wb;
  assign lane_en  = (state_q == RUN) && !wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (last_wb) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      relu_q    <= 1'b0;
      ch_q      <= '0;
      grp_q     <= '0;
      pos_q     <= '0;
      tap_q     <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        busy      <= 1'b1;
        out_valid <= 1'b0;
        relu_q    <= relu_en;
      end
      if (state_q == LOAD) begin
        ch_q  <= '0;
        grp_q <= '0;
        pos_q <= '0;
        tap_q <= '0;
      end
      if (state_q == RUN) begin
        if (wb) begin
          tap_q <= '0;
          if (pos_q == POS_IW'(OUT_W - 1)) begin
            pos_q <= '0;
            if (grp_q == G_IW'(G - 1)) begin
              grp_q <= '0;
              if (ch_q != CH_IW'(CH - 1)) ch_q <= ch_q + CH_IW'(1);
            end else begin
              grp_q <= grp_q + G_IW'(1);
            end
          end else begin
            pos_q <= pos_q + POS_IW'(1);
          end
        end else begin
          tap_q <= tap_q + TAP_IW'(1);
        end
      end
      if (state_q == DONE) begin
        done      <= 1'b1;
        out_valid <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      col_reg <= in_cols;
      ker_reg <= kernels;
    end
  end

  // Lanes past the last real column (or taps past the column end) see zero and are never written.
  always_comb begin
    int col_i;
    int smp_i;
    col_i    = 0;
    smp_i    = int'(pos_q) * STRIDE + int'(tap_q);
    kern_tap = '0;
    if (tap_q < TAP_IW'(K)) kern_tap = ker_reg[ch_q][KT_IW'(tap_q)];
    for (int l = 0; l < LANES; l++) begin
      col_i          = int'(grp_q) * LANES + l;
      lane_ok[l]     = (col_i < COLS);
      lane_col[l]    = lane_ok[l] ? COL_IW'(col_i) : '0;
      lane_sample[l] = '0;
      if (lane_ok[l] && smp_i < IN_LEN) begin
        lane_sample[l] = col_reg[lane_col[l]][SMP_IW'(smp_i)];
      end
      lane_res[l] = DATA_W'(sat_round(64'(lane_acc[l]), FRAC_W, DATA_W));
      if (relu_q && lane_res[l][DATA_W-1]) lane_res[l] = '0;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    col_mac_lane #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (lane_clr),
      .en    (lane_en),
      .sample(lane_sample[l]),
      .tap   (kern_tap),
      .acc   (lane_acc[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_values <= '{default: '0};
    end else if (wb) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_ok[l]) out_values[ch_q][lane_col[l]][pos_q] <= lane_res[l];
      end
    end
  end

endmodule

// File: tb/tb_col_conv_array.sv
// Scoreboard bench for col_conv_array: directed patterns on the default configuration and on a
// COLS=5/LANES=2 configuration whose last column group has a masked lane.
module tb_col_conv_array;

  localparam int DW     = 16;
  localparam int LEN    = 28;
  localparam int KT     = 8;
  localparam int NCH    = 2;
  localparam int OW     = 11;
  localparam int COLS_A = 11;
  localparam int COLS_B = 5;
  // 2 + CH*G*OUT_W*(K+1) = 2 + 2*3*11*9 for both configurations (G=3 in each).
  localparam int LAT    = 596;

  logic clk = 1'b0;
  logic rst;
  logic start_a;
  logic start_b;
  logic relu_en;
  logic signed [DW-1:0] cols_a [COLS_A][LEN];
  logic signed [DW-1:0] cols_b [COLS_B][LEN];
  logic signed [DW-1:0] ker [NCH][KT];
  logic busy_a, done_a, valid_a;
  logic busy_b, done_b, valid_b;
  logic signed [DW-1:0] out_a [NCH][COLS_A][OW];
  logic signed [DW-1:0] out_b [NCH][COLS_B][OW];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_a[$];
  int exp_b[$];
  int acc_a[$];
  int acc_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  col_conv_array u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .start     (start_a),
    .relu_en   (relu_en),
    .in_cols   (cols_a),
    .kernels   (ker),
    .busy      (busy_a),
    .done      (done_a),
    .out_valid (valid_a),
    .out_values(out_a)
  );

  col_conv_array #(
    .COLS (COLS_B),
    .LANES(2)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (start_b),
    .relu_en   (relu_en),
    .in_cols   (cols_b),
    .kernels   (ker),
    .busy      (busy_b),
    .done      (done_b),
    .out_valid (valid_b),
    .out_values(out_b)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Patterns: 0 identity (ch1 picks the odd sample), 1 box sum, 2 saturation, 3 rounding.
  function automatic int sampleOf(input int pattern, input int c, input int i);
    case (pattern)
      0:       return c * 16 + i;
      1:       return 256;
      2:       return 32512;
      default: return 1;
    endcase
  endfunction

  function automatic int expectedOf(input int pattern, input bit relu, input int ch,
                                    input int c, input int p);
    case (pattern)
      0:       return c * 16 + 2 * p + ch;
      1:       return (ch == 0) ? 2048 : (relu ? 0 : -2048);
      2:       return (ch == 0) ? 32767 : (relu ? 0 : -32768);
      default: return (ch == 0) ? 1 : 0;
    endcase
  endfunction

  // Called at a negedge: loads inputs, pulses start across one edge, queues the expected result.
  task automatic applyStimulus(input int dut, input int pattern, input bit relu, input bit expect_done);
    int ncol;
    ncol = (dut == 0) ? COLS_A : COLS_B;
    for (int ch = 0; ch < NCH; ch++)
      for (int t = 0; t < KT; t++) ker[ch][t] = '0;
    case (pattern)
      0: begin ker[0][0] = 16'sd256; ker[1][1] = 16'sd256; end
      1: for (int t = 0; t < KT; t++) begin ker[0][t] = 16'sd256; ker[1][t] = -16'sd256; end
      2: for (int t = 0; t < KT; t++) begin ker[0][t] = 16'sd32512; ker[1][t] = -16'sd32512; end
      default: begin ker[0][0] = 16'sd128; ker[1][0] = 16'sd64; end
    endcase
    for (int c = 0; c < ncol; c++)
      for (int i = 0; i < LEN; i++) begin
        if (dut == 0) cols_a[c][i] = DW'(sampleOf(pattern, c, i));
        else          cols_b[c][i] = DW'(sampleOf(pattern, c, i));
      end
    relu_en = relu;
    if (dut == 0) start_a = 1'b1; else start_b = 1'b1;
    if (expect_done) begin
      for (int ch = 0; ch < NCH; ch++)
        for (int c = 0; c < ncol; c++)
          for (int p = 0; p < OW; p++) begin
            if (dut == 0) exp_a.push_back(expectedOf(pattern, relu, ch, c, p));
            else          exp_b.push_back(expectedOf(pattern, relu, ch, c, p));
          end
      if (dut == 0) acc_a.push_back(cyc + 1); else acc_b.push_back(cyc + 1);
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int ch = 0; ch < NCH; ch++)
      for (int t = 0; t < KT; t++) ker[ch][t] = DW'($urandom);
    for (int c = 0; c < ncol; c++)
      for (int i = 0; i < LEN; i++) begin
        if (dut == 0) cols_a[c][i] = DW'($urandom);
        else          cols_b[c][i] = DW'($urandom);
      end
    relu_en = 1'($urandom);
  endtask

  task automatic compareResult(input int dut);
    int ncol;
    int got;
    int s;
    ncol = (dut == 0) ? COLS_A : COLS_B;
    if (((dut == 0) ? acc_a.size() : acc_b.size()) == 0) begin
      checkOutput($sformatf("dut%0d_unexpected_done", dut), 1, 0);
      return;
    end
    s = (dut == 0) ? acc_a.pop_front() : acc_b.pop_front();
    checkOutput($sformatf("dut%0d_latency", dut), cyc - s, LAT);
    for (int ch = 0; ch < NCH; ch++)
      for (int c = 0; c < ncol; c++)
        for (int p = 0; p < OW; p++) begin
          if (((dut == 0) ? exp_a.size() : exp_b.size()) == 0) begin
            checkOutput($sformatf("dut%0d_expect_missing", dut), 0, 1);
            return;
          end
          if (dut == 0) got = int'(out_a[ch][c][p]);
          else          got = int'(out_b[ch][c][p]);
          checkOutput($sformatf("dut%0d_out[%0d][%0d][%0d]", dut, ch, c, p), got,
                      (dut == 0) ? exp_a.pop_front() : exp_b.pop_front());
        end
  endtask

  always @(negedge clk) begin
    if (done_a) compareResult(0);
    if (done_b) compareResult(1);
  end

  task automatic waitDone(input int dut);
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if ((dut == 0) ? done_a : done_b) return;
    end
    checkOutput($sformatf("dut%0d_done_timeout", dut), 0, 1);
  endtask

  function automatic int nonzeroA();
    int n;
    n = 0;
    for (int ch = 0; ch < NCH; ch++)
      for (int c = 0; c < COLS_A; c++)
        for (int p = 0; p < OW; p++) if (out_a[ch][c][p] != 0) n++;
    return n;
  endfunction

  function automatic int nonzeroB();
    int n;
    n = 0;
    for (int ch = 0; ch < NCH; ch++)
      for (int c = 0; c < COLS_B; c++)
        for (int p = 0; p < OW; p++) if (out_b[ch][c][p] != 0) n++;
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    relu_en = 1'b0;
    for (int ch = 0; ch < NCH; ch++)
      for (int t = 0; t < KT; t++) ker[ch][t] = '0;
    for (int c = 0; c < COLS_A; c++)
      for (int i = 0; i < LEN; i++) cols_a[c][i] = '0;
    for (int c = 0; c < COLS_B; c++)
      for (int i = 0; i < LEN; i++) cols_b[c][i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy_a), 0);
    checkOutput("reset_done", int'(done_a), 0);
    checkOutput("reset_valid", int'(valid_a), 0);
    checkOutput("reset_out_nonzero", nonzeroA(), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] identity kernels");
    applyStimulus(0, 0, 1'b0, 1'b1);
    checkOutput("busy_after_accept", int'(busy_a), 1);
    waitDone(0);
    checkOutput("busy_at_done", int'(busy_a), 0);
    checkOutput("valid_at_done", int'(valid_a), 1);
    @(negedge clk);
    checkOutput("done_one_cycle", int'(done_a), 0);
    checkOutput("valid_held", int'(valid_a), 1);

    $display("[TB] box sum with relu, saturation, rounding");
    applyStimulus(0, 1, 1'b1, 1'b1);
    waitDone(0);
    @(negedge clk);
    applyStimulus(0, 2, 1'b0, 1'b1);
    waitDone(0);
    @(negedge clk);
    applyStimulus(0, 3, 1'b0, 1'b1);
    waitDone(0);
    @(negedge clk);

    $display("[TB] handshake");
    applyStimulus(0, 0, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checkOutput("busy_after_midrun_start", int'(busy_a), 1);
    waitDone(0);
    start_a = 1'b1;
    @(negedge clk);
    checkOutput("start_on_done_ignored_busy", int'(busy_a), 0);
    checkOutput("start_on_done_valid", int'(valid_a), 1);
    checkOutput("single_done", int'(done_a), 0);
    applyStimulus(0, 1, 1'b0, 1'b1);
    checkOutput("second_run_valid_low", int'(valid_a), 0);
    checkOutput("second_run_busy", int'(busy_a), 1);
    waitDone(0);
    checkOutput("second_run_valid_high", int'(valid_a), 1);
    @(negedge clk);

    $display("[TB] reset mid-run, default configuration");
    applyStimulus(0, 0, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", int'(busy_a), 0);
    checkOutput("abort_done", int'(done_a), 0);
    checkOutput("abort_valid", int'(valid_a), 0);
    checkOutput("abort_out_nonzero", nonzeroA(), 0);
    applyStimulus(0, 0, 1'b0, 1'b1);
    waitDone(0);
    @(negedge clk);

    $display("[TB] masked-lane configuration");
    applyStimulus(1, 1, 1'b0, 1'b1);
    waitDone(1);
    @(negedge clk);
    applyStimulus(1, 0, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("b_abort_busy", int'(busy_b), 0);
    checkOutput("b_abort_valid", int'(valid_b), 0);
    checkOutput("b_abort_out_nonzero", nonzeroB(), 0);
    applyStimulus(1, 0, 1'b0, 1'b1);
    waitDone(1);

    repeat (5) @(negedge clk);
    checkOutput("pending_runs_a", acc_a.size(), 0);
    checkOutput("pending_runs_b", acc_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
